// File: rtl/sn74193.sv
// sn74193: behavioural SN74193 synchronous 4-bit up/down binary counter.
// The chip's count clocks (up, down) are sampled on the master clock and
// edge-detected, so every register updates only on posedge mclk.
//
// Ports:
//   mclk      in   master simulation clock, all state updates on posedge
//   rst       in   synchronous active-high reset
//   up        in   count-up clock pin, counts on rising edge
//   down      in   count-down clock pin, counts on rising edge
//   clr       in   clear, active-high
//   load_n    in   parallel load, active-low, level-sensitive
//   d         in   parallel load data [WIDTH-1:0]
//   q         out  counter value [WIDTH-1:0]
//   carry_n   out  terminal-count-up pulse, active-low
//   borrow_n  out  terminal-count-down pulse, active-low
//   fault     out  sticky illegal-clocking flag (only with SN74193_FAULT_EN)
//
// Optional feature: define SN74193_FAULT_EN to add the fault output.
module sn74193 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             clr,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             carry_n,
`ifdef SN74193_FAULT_EN
  output logic             borrow_n,
  output logic             fault
`else
  output logic             borrow_n
`endif
);

  logic             old_up;
  logic             old_down;
  logic             up_rise;
  logic             down_rise;
  logic             count_en;
  logic [WIDTH-1:0] q_next;

  assign up_rise   = up && !old_up;
  assign down_rise = down && !old_down;
  assign count_en  = !clr && load_n;

  // Next counter value; a count edge only takes effect while the other
  // clock pin is idle high and not itself rising this cycle.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (!load_n) begin
      q_next = d;
    end else if (up_rise && down && !down_rise) begin
      q_next = q + 1'b1;
    end else if (down_rise && up && !up_rise) begin
      q_next = q - 1'b1;
    end
  end

  // Carry/borrow are computed from the value being written so that their
  // rising edge coincides with the wrap, giving a clean downstream clock.
  always_ff @(posedge mclk) begin
    if (rst) begin
      q        <= '0;
      carry_n  <= 1'b1;
      borrow_n <= 1'b1;
      old_up   <= 1'b1;
      old_down <= 1'b1;
    end else begin
      q        <= q_next;
      carry_n  <= !(!up && (q_next == '1));
      borrow_n <= !(!down && (q_next == '0));
      old_up   <= up;
      old_down <= down;
    end
  end

`ifdef SN74193_FAULT_EN
  // Sticky until reset: simultaneous count edges while counting, or an edge
  // on one pin while the other pin is low.
  always_ff @(posedge mclk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if ((count_en && up_rise && down_rise) ||
                 (up_rise && !down) || (down_rise && !up)) begin
      fault <= 1'b1;
    end
  end
`else
  logic unused_count_en;
  assign unused_count_en = count_en;
`endif

endmodule

// File: tb/tb_sn74193.sv
module tb_sn74193;

  localparam int unsigned W = 4;
  localparam int unsigned M = 1 << W;

  logic         mclk = 1'b0;
  logic         rst = 1'b1;
  logic         up = 1'b1;
  logic         down = 1'b1;
  logic         clr = 1'b0;
  logic         load_n = 1'b1;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         carry_n;
  logic         borrow_n;
  logic         dut_fault;

  always #5 mclk = ~mclk;

  sn74193 #(.WIDTH(W)) dut (
    .mclk    (mclk),
    .rst     (rst),
    .up      (up),
    .down    (down),
    .clr     (clr),
    .load_n  (load_n),
    .d       (d),
    .q       (q),
    .carry_n (carry_n),
`ifdef SN74193_FAULT_EN
    .borrow_n(borrow_n),
    .fault   (dut_fault)
`else
    .borrow_n(borrow_n)
`endif
  );

`ifndef SN74193_FAULT_EN
  assign dut_fault = 1'b0;
`endif

  typedef struct {
    int unsigned q;
    bit          carry_n;
    bit          borrow_n;
    bit          fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 0;

  // Reference model state
  int unsigned m_q = 0;
  bit m_prev_up = 1, m_prev_down = 1, m_fault = 0;
  bit m_carry = 1, m_borrow = 1;

  function automatic void check(input string name, input int unsigned got,
                                input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endfunction

  // Applies one mclk worth of inputs and pushes what the counter must show
  // after the following rising edge.
  task automatic tick(input bit r, input bit u, input bit dn, input bit c,
                      input bit ln, input int unsigned dd);
    bit ur, dr;
    exp_t e;
    @(negedge mclk);
    rst = r; up = u; down = dn; clr = c; load_n = ln; d = W'(dd);
    if (r) begin
      m_q = 0; m_carry = 1; m_borrow = 1; m_fault = 0;
      m_prev_up = 1; m_prev_down = 1;
    end else begin
      ur = u && !m_prev_up;
      dr = dn && !m_prev_down;
      if (c) m_q = 0;
      else if (!ln) m_q = dd % M;
      else if (ur && dr) m_q = m_q;                 // both edges: hold
      else if (ur && dn) m_q = (m_q + 1) % M;
      else if (dr && u) m_q = (m_q + M - 1) % M;
`ifdef SN74193_FAULT_EN
      if ((!c && ln && ur && dr) || (ur && !dn) || (dr && !u)) m_fault = 1;
`endif
      m_carry  = !(!u && m_q == M - 1);
      m_borrow = !(!dn && m_q == 0);
      m_prev_up = u;
      m_prev_down = dn;
    end
    e.q = m_q; e.carry_n = m_carry; e.borrow_n = m_borrow; e.fault = m_fault;
    sb.push_back(e);
  endtask

  // Hold the current inputs for n cycles, changing only the clock pins.
  task automatic pins(input bit u, input bit dn, input int n);
    for (int i = 0; i < n; i++) tick(0, u, dn, clr, load_n, d);
  endtask

  // Monitor: the counter presents a new output every mclk.
  initial begin
    exp_t e;
    forever begin
      @(posedge mclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q", q, e.q);
        check("carry_n", carry_n, e.carry_n);
        check("borrow_n", borrow_n, e.borrow_n);
`ifdef SN74193_FAULT_EN
        check("fault", dut_fault, e.fault);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: done=%0d expected=1", done);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then count up through wrap with down idle high.
    tick(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      pins(0, 1, 4);
      pins(1, 1, 4);
    end
    // Load 2, count down through zero.
    tick(0, 1, 1, 0, 0, 2);
    tick(0, 1, 1, 0, 1, 2);
    for (int i = 0; i < 3; i++) begin
      pins(1, 0, 4);
      pins(1, 1, 4);
    end
    // Priority: clr over load over an up edge.
    pins(0, 1, 2);
    tick(0, 1, 1, 1, 0, 9);
    tick(0, 0, 1, 0, 0, 9);
    tick(0, 1, 1, 0, 0, 9);
    tick(0, 1, 1, 0, 1, 9);
    pins(0, 1, 2);
    pins(1, 1, 2);
    // Illegal clocking: up edge with down low, then simultaneous edges.
    pins(0, 0, 2);
    pins(1, 0, 2);
    pins(0, 0, 2);
    pins(1, 1, 3);
    tick(1, 1, 1, 0, 1, 0);
    // Reset mid-operation with up held high.
    tick(0, 1, 1, 0, 0, 7);
    tick(0, 1, 1, 0, 1, 7);
    tick(1, 1, 1, 0, 1, 7);
    pins(1, 1, 2);
    pins(0, 1, 2);
    pins(1, 1, 2);
    // Randomized traffic, mostly counting with occasional clr/load/reset.
    for (int i = 0; i < 4000; i++) begin
      bit r, u, dn, c, ln;
      r  = ($urandom_range(0, 199) == 0);
      u  = ($urandom_range(0, 3) == 0) ? !up : up;
      dn = ($urandom_range(0, 3) == 0) ? !down : down;
      if ($urandom_range(0, 7) == 0) dn = 1;
      if ($urandom_range(0, 7) == 0) u = 1;
      c  = ($urandom_range(0, 49) == 0);
      ln = ($urandom_range(0, 39) != 0);
      tick(r, u, dn, c, ln, $urandom_range(0, M - 1));
    end
    repeat (3) @(negedge mclk);
    check("scoreboard_drained", sb.size(), 0);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
